mlp_neuron_acc: RTL and testbench
=================================

# mlp_neuron_acc

Per-neuron dot-product accumulator for the MLP datapath. Sits directly downstream of the fixed-point multiplier. Accepts one truncated Q(INT_DIGIT).(DECIMAL_DIGIT) product per handshake, sums NUM_INPUTS products in a guarded accumulator, and adds a bias. The result is then saturated back to the datapath width, optionally passed through ReLU, and presented on a valid/ready output to the next layer.

## Interface
Parameters:
- INT_DIGIT, 11: integer bits of the fixed-point format, sign included.
- DECIMAL_DIGIT, 5: fraction bits. W = INT_DIGIT + DECIMAL_DIGIT (default 16).
- NUM_INPUTS, 64: products per output value (≥1).
- ACC_GUARD, 8: extra accumulator MSBs. ACC_W = W + ACC_GUARD. Must satisfy 2^ACC_GUARD ≥ NUM_INPUTS+1, checked by elaboration-time assertion.
- RELU, 1: 1 = clamp negative results to 0; 0 = pass through.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- clear, in, 1: synchronous discard of the partial vector.
- in_valid, in, 1: product available.
- in_ready, out, 1: block accepts a product this cycle.
- in_product, in, W signed: multiplier result in the same Q format.
- bias, in, W signed: sampled on the handshake of product index 0.
- out_valid, out, 1: result available.
- out_ready, in, 1: downstream accepts the result.
- out_data, out, W signed: saturated (and optionally ReLU'd) neuron output.
- out_sat, out, 1: saturation occurred for the current out_data.

## Operation
- State machine with two states:
  - ACCUM: in_ready=1, out_valid=0.
  - OUTPUT: in_ready=0, out_valid=1.
- Input handshake: in_valid && in_ready. Products are sign-extended to ACC_W.
- Counter cnt runs 0..NUM_INPUTS-1, advancing only on an input handshake.
- cnt==0 handshake: acc ← sext(bias) + sext(in_product).
- Middle handshakes: acc ← acc + sext(in_product).
- Handshake with cnt==NUM_INPUTS-1: compute sum = acc + sext(in_product), or bias + product when NUM_INPUTS==1. Then:
  - Saturate sum to W bits: > 2^(W-1)-1 gives 0x7FFF..., < -2^(W-1) gives 0x8000...
  - out_sat = 1 if clamping occurred.
  - Apply ReLU if RELU==1 (negative becomes 0; out_sat unchanged by ReLU).
  - Register the result into out_data and go to OUTPUT.
- No bit dropping inside the accumulator. The guard bits guarantee that acc cannot wrap.
- OUTPUT state:
  - out_data and out_sat are held stable while out_ready=0.
  - On out_valid && out_ready: go to ACCUM, cnt←0, acc←0.
  - out_data keeps its last value; it is don't-care while out_valid=0.
- clear:
  - In ACCUM: cnt←0, acc←0. A same-cycle input handshake is discarded.
  - In OUTPUT: ignored. A completed result is never dropped.
- in_valid with in_ready=0 is ignored. The upstream stage holds its data.

## Timing
- Reset values: state=ACCUM, cnt=0, acc=0, in_ready=1, out_valid=0, out_data=0, out_sat=0.
- rst asserted mid-vector or mid-OUTPUT aborts immediately (asynchronous). The pending result is lost.
- Latency: out_valid rises the cycle after the last input handshake.
- Minimum period is NUM_INPUTS+1 cycles per result: NUM_INPUTS input cycles plus 1 OUTPUT cycle when out_ready=1.
- in_ready is 0 for every cycle in OUTPUT, including the cycle in which the output handshake occurs. Input resumes the following cycle.
- Gaps in in_valid stall accumulation with no loss of state.
- in_ready and out_valid are registered, with no combinational path from out_ready or in_valid.

## Test plan
Bench uses NUM_INPUTS=4 and W=16 Q11.5, so 1.0 = 0x0020.
- Basic sum: products 0x0020 ×4, bias 0x0010, in_valid held high.
  - out_data=0x0090 (4.5) and out_sat=0.
  - out_valid rises 1 cycle after the 4th handshake.
  - in_ready=0 during OUTPUT.
- Negative result: products 0xFFC0 (-2.0) ×4, bias 0.
  - RELU=1 → out_data=0x0000, out_sat=0.
  - RELU=0 → out_data=0xFF00.
- Saturation: products 0x7FFF ×4, bias 0x7FFF → out_data=0x7FFF, out_sat=1. Products 0x8000 ×4 with RELU=0 → out_data=0x8000, out_sat=1.
- Backpressure and gaps:
  - Random in_valid gaps, with bias sampled only at index 0 (changing bias later has no effect).
  - out_ready low for 5 cycles: out_data stays stable, in_valid pulses are not accepted, and the next vector starts correctly after the handshake.
- clear after 2 products: the next 4 products (0x0020 each, bias 0) give 0x0080. clear asserted during OUTPUT leaves the result intact.
- Async rst asserted between clock edges mid-vector: all outputs go to reset values immediately, and the following full vector produces the correct sum.

Source files
------------

// File: rtl/mlp_neuron_acc.sv
`default_nettype none
// ============================================================================
// Module      : mlp_neuron_acc
// Description : Per-neuron dot-product accumulator with bias, saturation and
//               optional ReLU, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_neuron_acc #(
    parameter int INT_DIGIT     = 11,
    parameter int DECIMAL_DIGIT = 5,
    parameter int NUM_INPUTS    = 64,
    parameter int ACC_GUARD     = 8,
    parameter int RELU          = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        clear,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic signed [INT_DIGIT+DECIMAL_DIGIT-1:0]   in_product,
    input  logic signed [INT_DIGIT+DECIMAL_DIGIT-1:0]   bias,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic signed [INT_DIGIT+DECIMAL_DIGIT-1:0]   out_data,
    output logic                                        out_sat
);

    localparam int c_W     = INT_DIGIT + DECIMAL_DIGIT;
    localparam int c_ACC_W = c_W + ACC_GUARD;
    localparam int c_CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NUM_INPUTS - 1);

    localparam logic [0:0] c_ST_ACCUM  = 1'b0;
    localparam logic [0:0] c_ST_OUTPUT = 1'b1;

    // Saturation bounds of the W-bit result, expressed at accumulator width
    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX = {{(ACC_GUARD+1){1'b0}}, {(c_W-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN = {{(ACC_GUARD+1){1'b1}}, {(c_W-1){1'b0}}};

    if (NUM_INPUTS < 1 || (2 ** ACC_GUARD) < (NUM_INPUTS + 1)) begin : g_param_check
        $error("mlp_neuron_acc: ACC_GUARD too small for NUM_INPUTS");
    end

    logic [0:0]                 r_state;
    logic [c_CNT_W-1:0]         r_cnt;
    logic signed [c_ACC_W-1:0]  r_acc;
    logic signed [c_W-1:0]      r_out_data;
    logic                       r_out_sat;

    logic                       w_hs;
    logic                       w_first;
    logic                       w_last;
    logic signed [c_ACC_W-1:0]  w_prod_ext;
    logic signed [c_ACC_W-1:0]  w_bias_ext;
    logic signed [c_ACC_W-1:0]  w_base;
    logic signed [c_ACC_W-1:0]  w_sum;
    logic signed [c_W-1:0]      w_clamped;
    logic signed [c_W-1:0]      w_result;
    logic                       w_sat;

    assign in_ready  = (r_state == c_ST_ACCUM);
    assign out_valid = (r_state == c_ST_OUTPUT);
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

    assign w_hs       = in_valid & in_ready;
    assign w_first    = (r_cnt == '0);
    assign w_last     = (r_cnt == c_LAST);
    assign w_prod_ext = {{ACC_GUARD{in_product[c_W-1]}}, in_product};
    assign w_bias_ext = {{ACC_GUARD{bias[c_W-1]}}, bias};
    // Index 0 seeds the sum with the bias instead of the running total
    assign w_base     = w_first ? w_bias_ext : r_acc;
    assign w_sum      = w_base + w_prod_ext;

    always_comb begin
        w_sat     = 1'b0;
        w_clamped = w_sum[c_W-1:0];
        if (w_sum > c_SAT_MAX) begin
            w_sat     = 1'b1;
            w_clamped = {1'b0, {(c_W-1){1'b1}}};
        end else if (w_sum < c_SAT_MIN) begin
            w_sat     = 1'b1;
            w_clamped = {1'b1, {(c_W-1){1'b0}}};
        end
    end

    if (RELU != 0) begin : g_relu_on
        assign w_result = w_clamped[c_W-1] ? '0 : w_clamped;
    end else begin : g_relu_off
        assign w_result = w_clamped;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_ACCUM;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_ACCUM: begin
                    if (clear) begin
                        r_cnt <= '0;
                        r_acc <= '0;
                    end else if (w_hs) begin
                        r_acc <= w_sum;
                        if (w_last) begin
                            r_out_data <= w_result;
                            r_out_sat  <= w_sat;
                            r_state    <= c_ST_OUTPUT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    // clear is deliberately ignored here so a finished result is never lost
                    if (out_ready) begin
                        r_state <= c_ST_ACCUM;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mlp_neuron_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlp_neuron_acc
// Description : Directed bench for mlp_neuron_acc, NUM_INPUTS=4, Q11.5,
//               one ReLU and one linear instance on shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_neuron_acc;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic signed [15:0] in_product;
    logic signed [15:0] bias;

    logic        relu_in_ready, relu_out_valid, relu_out_sat;
    logic signed [15:0] relu_out_data;
    logic        lin_in_ready, lin_out_valid, lin_out_sat;
    logic signed [15:0] lin_out_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mlp_neuron_acc #(
        .INT_DIGIT(11), .DECIMAL_DIGIT(5), .NUM_INPUTS(N), .ACC_GUARD(8), .RELU(1)
    ) u_relu (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(relu_in_ready),
        .in_product(in_product), .bias(bias),
        .out_valid(relu_out_valid), .out_ready(out_ready),
        .out_data(relu_out_data), .out_sat(relu_out_sat)
    );

    mlp_neuron_acc #(
        .INT_DIGIT(11), .DECIMAL_DIGIT(5), .NUM_INPUTS(N), .ACC_GUARD(8), .RELU(0)
    ) u_lin (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(lin_in_ready),
        .in_product(in_product), .bias(bias),
        .out_valid(lin_out_valid), .out_ready(out_ready),
        .out_data(lin_out_data), .out_sat(lin_out_sat)
    );

    typedef struct packed {
        logic [63:0] prods;     // {p0, p1, p2, p3}
        logic [15:0] bias;
        logic [15:0] exp_relu;
        logic [15:0] exp_lin;
        logic        exp_sat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one product and waits (bounded) for the handshake edge
    task automatic send(input logic [15:0] p, input logic [15:0] b);
        bit done;
        done       = 1'b0;
        in_valid   = 1'b1;
        in_product = p;
        bias       = b;
        for (int c = 0; c < 20 && !done; c++) begin
            done = relu_in_ready && lin_in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("in_handshake_timeout", 16'd0, 16'd1);
    endtask

    task automatic run_vec(input vec_t v, input bit gaps, input string tag);
        logic [15:0] p;
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bias = 16'($urandom);
                    tick();
                end
            end
            p = v.prods[63 - 16*k -: 16];
            send(p, (k == 0) ? v.bias : 16'($urandom));
            if (k == N - 2) check({tag, "_busy_valid"}, 16'(lin_out_valid), 16'd0);
        end
        check({tag, "_out_valid"}, 16'({relu_out_valid, lin_out_valid}), 16'd3);
        check({tag, "_in_ready"},  16'({relu_in_ready, lin_in_ready}), 16'd0);
        check({tag, "_relu_data"}, relu_out_data, v.exp_relu);
        check({tag, "_lin_data"},  lin_out_data, v.exp_lin);
        check({tag, "_sat"},       16'({relu_out_sat, lin_out_sat}), {14'd0, v.exp_sat, v.exp_sat});
    endtask

    task automatic out_hs(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_after_hs"}, 16'({relu_out_valid, relu_in_ready}), 16'b01);
    endtask

    vec_t basic;
    vec_t sat_v;
    vec_t ones_v;
    logic [15:0] held;

    initial begin
        vecs[0] = '{64'h0020_0020_0020_0020, 16'h0010, 16'h0090, 16'h0090, 1'b0};
        vecs[1] = '{64'hFFC0_FFC0_FFC0_FFC0, 16'h0000, 16'h0000, 16'hFF00, 1'b0};
        vecs[2] = '{64'h7FFF_7FFF_7FFF_7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
        vecs[3] = '{64'h8000_8000_8000_8000, 16'h0000, 16'h0000, 16'h8000, 1'b1};
        vecs[4] = '{64'h0100_FF80_0040_FFF0, 16'h0008, 16'h00B8, 16'h00B8, 1'b0};
        vecs[5] = '{64'h4000_4000_C000_3FFF, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0};
        vecs[6] = '{64'hC000_C000_0000_0000, 16'h0000, 16'h0000, 16'h8000, 1'b0};
        vecs[7] = '{64'h4000_4000_0000_0000, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1};
        basic   = vecs[0];
        sat_v   = vecs[2];
        ones_v  = '{64'h0020_0020_0020_0020, 16'h0000, 16'h0080, 16'h0080, 1'b0};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_product = '0; bias = '0;
        #1;
        check("reset_ready_valid", 16'({relu_in_ready, relu_out_valid, lin_in_ready, lin_out_valid}), 16'b1010);
        check("reset_data", relu_out_data | lin_out_data, 16'h0000);
        check("reset_sat", 16'({relu_out_sat, lin_out_sat}), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i[0], $sformatf("vec%0d", i));
            out_hs($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold and input must be refused for 5 cycles
        run_vec(basic, 1'b1, "bp");
        held = lin_out_data;
        for (int c = 0; c < 5; c++) begin
            in_valid   = c[0];
            in_product = 16'h7FFF;
            tick();
            check($sformatf("bp_hold%0d", c), lin_out_data, held);
            check($sformatf("bp_state%0d", c), 16'({lin_out_valid, lin_in_ready}), 16'b10);
        end
        in_valid = 1'b0;
        out_hs("bp");
        run_vec(basic, 1'b0, "bp_next");
        out_hs("bp_next");

        // clear after two products; the same-cycle handshake is discarded
        send(16'h0020, 16'h0000);
        send(16'h0020, 16'h0000);
        clear = 1'b1; in_valid = 1'b1; in_product = 16'h0400;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        run_vec(ones_v, 1'b0, "clr");
        clear = 1'b1;
        repeat (2) tick();
        clear = 1'b0;
        check("clr_output_kept_valid", 16'(lin_out_valid), 16'd1);
        check("clr_output_kept_data", lin_out_data, 16'h0080);
        out_hs("clr");

        // Async reset mid-vector, between clock edges
        send(16'h0020, 16'h0000);
        send(16'h0020, 16'h0000);
        #3;
        rst = 1'b1;
        #1;
        check("arst_mid_state", 16'({relu_in_ready, relu_out_valid}), 16'b10);
        check("arst_mid_data", lin_out_data, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        run_vec(basic, 1'b0, "arst_vec");
        out_hs("arst_vec");

        // Async reset while a saturated result is pending
        run_vec(sat_v, 1'b0, "arst_out");
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_state", 16'({lin_in_ready, lin_out_valid}), 16'b10);
        check("arst_out_data", lin_out_data, 16'h0000);
        check("arst_out_sat", 16'(lin_out_sat), 16'd0);
        tick();
        rst = 1'b0;
        tick();
        run_vec(basic, 1'b1, "arst_after");
        out_hs("arst_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
